// File: rtl/rt_req_arbiter.sv
// rtl/rt_req_arbiter.sv - two-port racetrack memory request arbiter with response watchdog
//
// Arbitrates an instruction and a data requester onto one racetrack memory port,
// keeping at most one transaction in flight. Each transaction is
// IDLE/RESP (grant) -> ISSUE -> WAIT -> RESP.
//
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   {ins,dat}_req_i           request; fields below must be held until granted
//   {ins,dat}_gnt_o           combinational grant; fields are captured this cycle
//   {ins,dat}_addr_i/we_i/be_i/wdata_i/funct_i   request fields
//   {ins,dat}_rvalid_o        one-cycle completion pulse to the owner
//   {ins,dat}_rdata_o         response data, held between pulses
//   {ins,dat}_err_o           watchdog timeout flag, qualified by rvalid
//   mem_en_o                  memory request enable (ISSUE and WAIT)
//   mem_addr_o/we_o/be_o/wdata_o/funct_o          latched transaction fields
//   mem_rvalid_i, mem_rdata_i memory completion pulse and read data
module rt_req_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ins_req_i,
  output logic                  ins_gnt_o,
  input  logic [ADDR_WIDTH-1:0] ins_addr_i,
  input  logic                  ins_we_i,
  input  logic [3:0]            ins_be_i,
  input  logic [DATA_WIDTH-1:0] ins_wdata_i,
  input  logic [2:0]            ins_funct_i,
  output logic                  ins_rvalid_o,
  output logic [DATA_WIDTH-1:0] ins_rdata_o,
  output logic                  ins_err_o,
  input  logic                  dat_req_i,
  output logic                  dat_gnt_o,
  input  logic [ADDR_WIDTH-1:0] dat_addr_i,
  input  logic                  dat_we_i,
  input  logic [3:0]            dat_be_i,
  input  logic [DATA_WIDTH-1:0] dat_wdata_i,
  input  logic [2:0]            dat_funct_i,
  output logic                  dat_rvalid_o,
  output logic [DATA_WIDTH-1:0] dat_rdata_o,
  output logic                  dat_err_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_funct_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [9:0] WDOG_LOAD = 10'(TIMEOUT_CYCLES);

  state_t                state_q;
  logic                  owner_q;     // 1 = dat owns the transaction in flight
  logic                  last_dat_q;  // 1 = dat was granted most recently
  logic [9:0]            wdog_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] ins_rdata_q;
  logic [DATA_WIDTH-1:0] dat_rdata_q;

  logic                  arb_en;
  logic                  pick_dat;
  logic                  any_gnt;
  logic                  in_wait;
  logic                  done;
  logic                  timeout;
  logic                  in_resp;
  logic [DATA_WIDTH-1:0] resp_data;

  // Grants are only offered between transactions; gating with rstn_i keeps
  // them low while the block is held in reset.
  assign arb_en    = rstn_i && ((state_q == S_IDLE) || (state_q == S_RESP));
  // On a tie the port that did not win last time goes first.
  assign pick_dat  = dat_req_i && (!ins_req_i || !last_dat_q);
  assign dat_gnt_o = arb_en && pick_dat;
  assign ins_gnt_o = arb_en && ins_req_i && !pick_dat;
  assign any_gnt   = ins_gnt_o || dat_gnt_o;

  // A memory response arriving together with watchdog expiry counts as a
  // normal completion, so timeout requires mem_rvalid_i low.
  assign in_wait   = (state_q == S_WAIT);
  assign done      = in_wait && (mem_rvalid_i || (wdog_q == 10'd0));
  assign timeout   = in_wait && !mem_rvalid_i && (wdog_q == 10'd0);
  assign resp_data = mem_rvalid_i ? mem_rdata_i : '0;

  // Enable drops in the completing WAIT cycle, not one cycle later.
  assign mem_en_o  = (state_q == S_ISSUE) || (in_wait && !done);

  assign in_resp      = (state_q == S_RESP);
  assign ins_rvalid_o = in_resp && !owner_q;
  assign dat_rvalid_o = in_resp && owner_q;
  assign ins_err_o    = in_resp && !owner_q && err_q;
  assign dat_err_o    = in_resp && owner_q && err_q;
  assign ins_rdata_o  = ins_rdata_q;
  assign dat_rdata_o  = dat_rdata_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_dat_q  <= 1'b0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      ins_rdata_q <= '0;
      dat_rdata_q <= '0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      mem_funct_o <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (any_gnt) begin
            state_q     <= S_ISSUE;
            owner_q     <= pick_dat;
            last_dat_q  <= pick_dat;
            err_q       <= 1'b0;
            mem_addr_o  <= pick_dat ? dat_addr_i  : ins_addr_i;
            mem_we_o    <= pick_dat ? dat_we_i    : ins_we_i;
            mem_be_o    <= pick_dat ? dat_be_i    : ins_be_i;
            mem_wdata_o <= pick_dat ? dat_wdata_i : ins_wdata_i;
            mem_funct_o <= pick_dat ? dat_funct_i : ins_funct_i;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          wdog_q  <= WDOG_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            state_q <= S_RESP;
            err_q   <= timeout;
            if (owner_q) begin
              dat_rdata_q <= resp_data;
            end else begin
              ins_rdata_q <= resp_data;
            end
          end else begin
            wdog_q <= wdog_q - 10'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rt_req_arbiter.md
RT_REQ_ARBITER -- requirements
Module: rt_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 22, racetrack word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog load value (range 1..1023).
REQ-004 SHALL have port clk_i  in  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports {ins,dat}_req_i  in  1  request from the instruction / data requester.
REQ-007 SHALL have ports {ins,dat}_gnt_o  out  1  grant; the request fields are captured in this cycle.
REQ-008 SHALL have ports {ins,dat}_addr_i  in  ADDR_WIDTH  request address.
REQ-009 SHALL have ports {ins,dat}_we_i  in  1  write enable (1 = write).
REQ-010 SHALL have ports {ins,dat}_be_i  in  4  byte enables.
REQ-011 SHALL have ports {ins,dat}_wdata_i  in  DATA_WIDTH  write data.
REQ-012 SHALL have ports {ins,dat}_funct_i  in  3  logic-in-memory function code (000 = plain access).
REQ-013 SHALL have ports {ins,dat}_rvalid_o  out  1  one-cycle completion pulse.
REQ-014 SHALL have ports {ins,dat}_rdata_o  out  DATA_WIDTH  response data.
REQ-015 SHALL have ports {ins,dat}_err_o  out  1  timeout flag, qualified by rvalid.
REQ-016 SHALL have port mem_en_o  out  1  memory request enable.
REQ-017 SHALL have ports mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o/mem_funct_o  out  ADDR_WIDTH/1/4/DATA_WIDTH/3  latched transaction fields.
REQ-018 SHALL have port mem_rvalid_i  in  1  memory completion pulse.
REQ-019 SHALL have port mem_rdata_i  in  DATA_WIDTH  memory read data.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE: if any req_i is high, SHALL assert exactly one gnt_o combinationally in the same cycle, latch that port's fields, record the owner and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-022 Arbitration: when exactly one port requests, that port SHALL win; when both request, the port not granted last SHALL win; the last-granted flag SHALL reset to ins, so dat wins the first tie.
REQ-023 ISSUE: SHALL assert mem_en_o, load the watchdog with TIMEOUT_CYCLES and go to WAIT.
REQ-024 WAIT: SHALL hold mem_en_o high and keep all mem_* fields stable.
REQ-025 WAIT: SHALL decrement the watchdog by 1 each cycle.
REQ-026 WAIT: on mem_rvalid_i SHALL deassert mem_en_o in the same cycle (combinationally), register mem_rdata_i and go to RESP.
REQ-027 WAIT: if the watchdog is 0 and mem_rvalid_i is low, SHALL deassert mem_en_o, set the pending error, force the registered rdata to 0 and go to RESP.
REQ-028 When mem_rvalid_i and watchdog = 0 occur in the same cycle, the valid SHALL win and no error SHALL be reported.
REQ-029 RESP: SHALL pulse the owner's rvalid_o for one cycle, drive rdata_o from the register, and drive err_o equal to the pending error.
REQ-030 In every cycle other than the owner's RESP cycle, rvalid_o and err_o SHALL be 0 and rdata_o SHALL hold its last value.
REQ-031 RESP: SHALL arbitrate per REQ-021/REQ-022 and go to ISSUE if a request is granted, otherwise go to IDLE; this allows back-to-back transactions with no IDLE cycle.
REQ-032 Read latency SHALL be: req at cycle 0, mem_en_o at cycle 1, rvalid_o one cycle after mem_rvalid_i.
REQ-033 gnt_o SHALL never assert in ISSUE or WAIT; requests in those states SHALL wait, and requesters SHALL hold req_i and the request fields until granted.
REQ-034 mem_rvalid_i outside WAIT SHALL be ignored.
REQ-035 At most one transaction SHALL be outstanding; gnt_o of both ports SHALL never be high together.
REQ-036 Reads SHALL return mem_rdata_i unchanged; writes SHALL return the data registered from mem_rdata_i when mem_rvalid_i pulsed.

Reset
REQ-037 When rstn_i is low, the block SHALL asynchronously go to IDLE, and mem_en_o, all gnt_o, rvalid_o and err_o, the watchdog, the error flag and the last-granted flag (ins) SHALL be 0.
REQ-038 When rstn_i is low, the mem_* fields and rdata_o SHALL be 0.
REQ-039 Reset mid-transaction SHALL abort the transaction with no response pulse, and the block SHALL be ready in IDLE on the first edge after release.

Verification
REQ-040 Single dat read at addr 0x00010, memory returns 0xDEADBEEF after 5 cycles -> dat_gnt_o at cycle 0, mem_en_o cycles 1..6, dat_rvalid_o pulses once with 0xDEADBEEF, dat_err_o=0.
REQ-041 ins and dat request together in 4 consecutive rounds -> grant order dat, ins, dat, ins; exactly one gnt per round.
REQ-042 Back-to-back: dat write (be=0011, funct=010) then ins read pending during WAIT -> ins granted in the dat RESP cycle, mem_en_o rises the next cycle, mem_funct_o=010 during the first transaction.
REQ-043 TIMEOUT_CYCLES=4, memory never responds -> mem_en_o falls after the watchdog expires, owner sees rvalid_o=1, err_o=1, rdata_o=0; a later request completes normally.
REQ-044 mem_rvalid_i injected while IDLE, and mem_rvalid_i coincident with watchdog=0 -> the first is ignored; the second gives a normal response with err_o=0.
REQ-045 rstn_i pulled low during WAIT -> all outputs 0 immediately, no rvalid_o pulse; a new request after release is granted in its first cycle.
